// File: rtl/score_keeper_if.sv
// Event and score bundle between game logic (master) and score_keeper (slave).
// BCD score fields exist only when SCORE_KEEPER_BCD_EN is defined.
interface score_keeper_if;
    logic        tick;
    logic        start;
    logic        bean;
    logic        hit;
    logic [31:0] score;
    logic [31:0] score_hi;
    logic        playing;
    logic        game_over;
    logic        new_hi;
`ifdef SCORE_KEEPER_BCD_EN
    logic [15:0] score_bcd;
    logic [15:0] score_hi_bcd;

    modport master (output tick, start, bean, hit,
                    input  score, score_hi, playing, game_over, new_hi, score_bcd, score_hi_bcd);
    modport slave  (input  tick, start, bean, hit,
                    output score, score_hi, playing, game_over, new_hi, score_bcd, score_hi_bcd);
`else
    modport master (output tick, start, bean, hit,
                    input  score, score_hi, playing, game_over, new_hi);
    modport slave  (input  tick, start, bean, hit,
                    output score, score_hi, playing, game_over, new_hi);
`endif
endinterface

// File: rtl/score_keeper.sv
// Goose-run score keeper: survival ticks and bean bonuses drain one point per clock into
// the score; the high score latches at run end. SCORE_KEEPER_BCD_EN adds BCD score mirrors.
module score_keeper #(
    parameter int TICK_DIV  = 6,
    parameter int BONUS     = 50,
    parameter int MAX_SCORE = 9999
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    score_keeper_if.slave sk,
    output logic [1:0]   o_dbg_state,
    output logic [9:0]   o_dbg_pending
);
    // Event pulses are single-cycle; there is no back-pressure, every pulse is consumed
    // on the edge it is sampled, and all outputs are registered.
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_OVER = 2'd2} state_t;

    localparam int              DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [31:0]     MAX_S    = 32'(MAX_SCORE);
    localparam logic [11:0]     BONUS_W  = 12'(BONUS);

    state_t           r_state, w_state_nxt;
    logic [DIV_W-1:0] r_div;
    logic [9:0]       r_pending;
    logic [31:0]      r_score, r_score_hi;
    logic             r_playing, r_game_over, r_new_hi;

    logic             w_start_run, w_live, w_point, w_sat, w_drain, w_new_hi_set;
    logic [11:0]      w_pend_sum;
    logic [9:0]       w_pend_nxt;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (sk.start) w_state_nxt = S_RUN;
            S_RUN:   if (sk.hit)   w_state_nxt = S_OVER;
            S_OVER:  if (sk.start) w_state_nxt = S_RUN;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // A hit suppresses every same-cycle point, bean and drain.
    always_comb begin
        w_start_run  = ((r_state == S_IDLE) || (r_state == S_OVER)) && sk.start;
        w_live       = (r_state == S_RUN) && !sk.hit;
        w_point      = w_live && sk.tick && (r_div == DIV_LAST);
        w_sat        = (r_score >= MAX_S);
        w_drain      = w_live && (r_pending != 10'd0) && !w_sat;
        w_new_hi_set = (r_state == S_RUN) && sk.hit && (r_score > r_score_hi);
        w_pend_sum   = {2'b00, r_pending}
                     + ((w_live && sk.bean) ? BONUS_W : 12'd0)
                     + {11'd0, w_point}
                     - {11'd0, w_drain};
        w_pend_nxt   = (w_pend_sum > 12'd1023) ? 10'h3FF : w_pend_sum[9:0];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_playing   <= 1'b0;
            r_game_over <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_playing   <= (w_state_nxt == S_RUN);
            r_game_over <= (w_state_nxt == S_OVER);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div      <= '0;
            r_pending  <= '0;
            r_score    <= '0;
            r_score_hi <= '0;
            r_new_hi   <= 1'b0;
        end else if (w_start_run) begin
            r_div     <= '0;
            r_pending <= '0;
            r_score   <= '0;
            r_new_hi  <= 1'b0;
        end else if (r_state == S_RUN) begin
            if (sk.hit) begin
                r_pending <= '0;
                if (w_new_hi_set) begin
                    r_score_hi <= r_score;
                    r_new_hi   <= 1'b1;
                end
            end else begin
                if (sk.tick) r_div <= (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);
                r_pending <= w_sat ? 10'd0 : w_pend_nxt;
                if (w_drain) r_score <= r_score + 32'd1;
            end
        end
    end

`ifdef SCORE_KEEPER_BCD_EN
    logic [15:0] r_score_bcd, r_score_hi_bcd;

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int d = 0; d < 4; d++) begin
            if (carry) begin
                if (r[4*d +: 4] == 4'd9) begin
                    r[4*d +: 4] = 4'd0;
                end else begin
                    r[4*d +: 4] = r[4*d +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Tracks r_score digit-for-digit: same clear, same single-step increment.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_score_bcd    <= '0;
            r_score_hi_bcd <= '0;
        end else if (w_start_run) begin
            r_score_bcd <= '0;
        end else begin
            if (w_drain)      r_score_bcd    <= bcd_inc(r_score_bcd);
            if (w_new_hi_set) r_score_hi_bcd <= r_score_bcd;
        end
    end

    assign sk.score_bcd    = r_score_bcd;
    assign sk.score_hi_bcd = r_score_hi_bcd;
`endif

    assign sk.score      = r_score;
    assign sk.score_hi   = r_score_hi;
    assign sk.playing    = r_playing;
    assign sk.game_over  = r_game_over;
    assign sk.new_hi     = r_new_hi;
    assign o_dbg_state   = r_state;
    assign o_dbg_pending = r_pending;
endmodule

// File: doc/score_keeper.md
# score_keeper

Sequential score producer for the goose-run game: counts survival time and bean bonuses into the current score and latches the high score when a run ends. Its `score` and `score_hi` outputs are the 32-bit binary values consumed by the 4-digit score and high-score renderers. It sits between the game-logic event pulses (frame tick, bean pickup, collision, start) and the drawing pipeline.

## Interface
- `TICK_DIV`, 6, frame ticks per survival point (≥1)
- `BONUS`, 50, points credited per bean pickup (1..255)
- `MAX_SCORE`, 9999, saturation value; the 4 displayed digits cannot show more
- `clk` input 1: system clock
- `rst_n` input 1: asynchronous, active-low reset
- `tick` input 1: one-cycle frame pulse, 60 Hz
- `start` input 1: one-cycle pulse that begins a new run
- `bean` input 1: one-cycle pulse, bean collected
- `hit` input 1: one-cycle pulse, fatal collision
- `score` output 32: current-run score, binary
- `score_hi` output 32: highest completed-run score, binary
- `playing` output 1: high in RUN
- `game_over` output 1: high in OVER
- `new_hi` output 1: high in OVER when the last run set a new high score

## Operation
- FSM states: IDLE, RUN, OVER.
  - IDLE→RUN and OVER→RUN on `start`.
  - RUN→OVER on `hit`.
  - `start` is ignored in RUN.
- Entering RUN clears `score`, the pending bank, the tick divider and `new_hi`.
- Tick divider, 0..TICK_DIV-1:
  - Advances on `tick` in RUN only.
  - On `tick` at TICK_DIV-1 it wraps to 0 and generates one point.
- Pending bank, 10-bit, saturates at 1023.
  - Each cycle: `pending <= pending + (bean ? BONUS : 0) + (point ? 1 : 0) - drain`.
  - `drain` = 1 when pending > 0 and score < MAX_SCORE.
  - On drain, `score` increments by exactly 1. Score never changes by more than 1 per clock.
- At `score == MAX_SCORE`:
  - Increments stop.
  - Pending is cleared.
  - Ticks and beans are still accepted but have no effect.
- `hit` in RUN has priority over everything:
  - Same-cycle point, bean and drain are discarded; `score` holds its pre-edge value.
  - Pending is cleared.
- On the RUN→OVER edge:
  - If `score > score_hi` (strictly greater), then `score_hi <= score` and `new_hi <= 1`.
  - A tie leaves both unchanged.
- In IDLE and OVER, `tick`, `bean` and `hit` are ignored. `score` holds, so the final run score stays visible.
- `score_hi` persists across runs and is cleared only by reset.

## Timing
- Reset values:
  - state IDLE
  - `score` = 0, `score_hi` = 0
  - pending 0, divider 0
  - `playing` = 0, `game_over` = 0, `new_hi` = 0
- Reset asserted mid-run forces the reset values immediately, asynchronously. No high-score update occurs.
- All outputs are registered. `playing`/`game_over` change at the same edge as the state.
- Point latency: `tick` at edge n produces pending +1 at n+1 and `score` +1 at n+2.
- Bean latency:
  - `bean` at edge n produces pending += BONUS at n+1.
  - `score` then rises by 1 per clock from n+2 and completes BONUS points at edge n+1+BONUS, absent other events.
- `score_hi` and `new_hi` update on the same edge as `game_over` rises.

## Configuration
- `SCORE_KEEPER_BCD_EN` defined: adds outputs `score_bcd[15:0]` and `score_hi_bcd[15:0]`, packed 4-digit BCD with thousands in [15:12].
  - `score_bcd` is a BCD counter that increments with every drain and ripple-carries 9→0.
  - It clears with `score` and saturates with it at 9999.
  - `score_hi_bcd` is copied from `score_bcd` when `score_hi` updates.
  - Reset values are 0. The BCD outputs always equal the binary outputs in decimal.
- Undefined: the ports and counters do not exist, and the renderer performs binary-to-decimal conversion itself.

## Test plan
- Reset, `start`, 12 `tick` pulses (TICK_DIV=6) → `score` = 2, `playing` = 1; `score` rises exactly 2 cycles after the 6th and 12th tick.
- RUN with score 0, one `bean` → `score` climbs 1/clock to 50 over cycles n+2..n+51; `bean` on a tick-wrap cycle adds 51 total.
- Run ending at 37 via `hit` with `score_hi` = 20 → `score_hi` = 37, `new_hi` = 1, `game_over` = 1; next run ending at 37 → `score_hi` stays 37, `new_hi` = 0.
- `hit` in the same cycle as a drain and a `bean` → `score` frozen at its pre-edge value, no further increments; `start` in OVER clears `score` to 0 and keeps `score_hi`.
- Drive `score` to 9999 with beans → holds at 9999 with pending 0; with BCD_EN, `score_bcd` = 16'h9999.
- Assert `rst_n` low mid-bonus-drain → all outputs 0 immediately, state IDLE; `tick`/`bean` in IDLE leave `score` at 0.
